// File: rtl/mt19937_sched_pkg.sv
// mt19937_sched shared definitions: FSM encoding,
// default seed and grant index width.
package mt19937_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEED,
    S_WAIT_GEN,
    S_STREAM
  } state_t;

  localparam logic [31:0] MT_SEED_DEFAULT = 32'd19650218;
  localparam int GID_W = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester after ptr, wrapping.
// Ports: req, ptr in; gnt (one-hot), idx out. Combinational.
module rr_arbiter
  import mt19937_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [GID_W-1:0]   idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] &&
            ((int'(ptr) + k) % NUM_REQ) == i) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          idx    = GID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mt19937_sched.sv
// Seed owner and burst arbiter in front of an MT19937 AXI-Stream source.
// Ports: cfg_seed_* host reseed, gen_* generator side, req_*/m_* consumers.
module mt19937_sched
  import mt19937_sched_pkg::*;
#(
  parameter int          NUM_REQ      = 4,
  parameter int          BURST_W      = 8,
  parameter logic [31:0] SEED_DEFAULT = MT_SEED_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                cfg_seed_val,
  input  logic                       cfg_seed_start,
  output logic [31:0]                gen_seed_val,
  output logic                       gen_seed_start,
  input  logic                       gen_busy,
  input  logic [31:0]                gen_tdata,
  input  logic                       gen_tvalid,
  output logic                       gen_tready,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*BURST_W-1:0] req_len,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [31:0]                m_tdata,
  output logic [NUM_REQ-1:0]         m_tvalid,
  input  logic [NUM_REQ-1:0]         m_tready,
  output logic [NUM_REQ-1:0]         m_tlast,
  output logic [GID_W-1:0]           grant_id,
  output logic                       busy,
  output logic [31:0]                words_served
);

  state_t state, state_nx;

  logic [31:0]        seed_reg;
  logic               seed_pend;
  logic [BURST_W-1:0] rem;
  logic [GID_W-1:0]   rr_ptr;
  logic [1:0]         wait_cnt;

  logic [NUM_REQ-1:0] gnt;
  logic [GID_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gsel;
  logic [BURST_W-1:0] len_sel;
  logic               xfer;
  logic               grant_go;
  logic               wait_done;
  logic               last_word;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  always_comb begin
    gsel    = '0;
    len_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GID_W'(i))
        gsel[i] = 1'b1;
      if (gnt[i])
        len_sel = req_len[i*BURST_W +: BURST_W];
    end
  end

  assign wait_done    = (wait_cnt != 2'd0);
  assign last_word    = (rem == '0);
  assign gen_seed_val = seed_reg;
  assign m_tdata      = gen_tdata;
  assign busy         = seed_pend
                      | (state == S_SEED)
                      | (state == S_WAIT_GEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    gen_seed_start = 1'b0;
    gen_tready     = 1'b0;
    req_ready      = '0;
    m_tvalid       = '0;
    m_tlast        = '0;
    xfer           = 1'b0;
    grant_go       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (seed_pend) begin
          state_nx = S_SEED;
        end else if (|req_valid) begin
          grant_go  = 1'b1;
          req_ready = gnt;
          state_nx  = S_STREAM;
        end
      end
      S_SEED: begin
        gen_seed_start = 1'b1;
        state_nx       = S_WAIT_GEN;
      end
      S_WAIT_GEN: begin
        if (wait_done && !gen_busy)
          state_nx = S_IDLE;
      end
      S_STREAM: begin
        m_tvalid   = gsel & {NUM_REQ{gen_tvalid}};
        m_tlast    = gsel & {NUM_REQ{last_word}};
        gen_tready = |(gsel & m_tready);
        xfer       = gen_tvalid & gen_tready;
        if (xfer && last_word)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_reg     <= SEED_DEFAULT;
      seed_pend    <= 1'b1;
      rem          <= '0;
      rr_ptr       <= GID_W'(NUM_REQ - 1);
      grant_id     <= '0;
      words_served <= '0;
      wait_cnt     <= '0;
    end else begin
      // a new host pulse beats the clear on SEED entry
      if (cfg_seed_start) begin
        seed_reg  <= cfg_seed_val;
        seed_pend <= 1'b1;
      end else if (state == S_IDLE && seed_pend) begin
        seed_pend <= 1'b0;
      end

      // len 0 wraps to all-ones: a full 2^BURST_W burst
      if (grant_go) begin
        rem      <= len_sel - BURST_W'(1);
        grant_id <= gnt_idx;
      end else if (xfer) begin
        rem <= rem - BURST_W'(1);
      end

      if (xfer) begin
        words_served <= words_served + 32'd1;
        if (last_word)
          rr_ptr <= grant_id;
      end

      if (state == S_WAIT_GEN) begin
        if (!wait_done)
          wait_cnt <= wait_cnt + 2'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule
